// File: rtl/stage_sequencer_pkg.sv
// Shared types and sizing for the fp16 stage-6 step/stage sequencer.
// Also holds the job-table validity check used when a start is accepted.
package seq_pkg;

  localparam int unsigned STEP_W     = 16;
  localparam int unsigned NUM_STAGES = 8;
  localparam int unsigned STAGE_W    = $clog2(NUM_STAGES + 1);
  localparam int unsigned TABLE_W    = NUM_STAGES * STEP_W;

  typedef logic [STEP_W-1:0]  step_t;
  typedef logic [STAGE_W-1:0] stage_t;
  typedef logic [TABLE_W-1:0] table_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // A table is usable when it is non-decreasing and the last boundary is non-zero
  function automatic logic cfg_valid(input table_t bnd);
    logic ok;
    ok = (bnd[(NUM_STAGES-1)*STEP_W +: STEP_W] != '0);
    for (int unsigned k = 1; k < NUM_STAGES; k++) begin
      if (bnd[k*STEP_W +: STEP_W] < bnd[(k-1)*STEP_W +: STEP_W]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Job-loader / datapath side bus of the stage sequencer.
// The sequencer uses the slave view; the loader/bench uses the master view.
interface stage_sequencer_if;
  import seq_pkg::*;

  logic   start_i;
  table_t boundary_i;
  logic [NUM_STAGES-1:0] clr_mask_i;
  logic   stall_i;

  logic   busy_o;
  step_t  step_o;
  stage_t stage_o;
  logic   mode_o;
  logic   add_sel_o;
  logic   red_clr_o;
  logic   done_o;
  logic   finished_o;
  logic   cfg_err_o;

  modport slave (
    input  start_i, boundary_i, clr_mask_i, stall_i,
    output busy_o, step_o, stage_o, mode_o, add_sel_o,
           red_clr_o, done_o, finished_o, cfg_err_o
  );

  modport master (
    output start_i, boundary_i, clr_mask_i, stall_i,
    input  busy_o, step_o, stage_o, mode_o, add_sel_o,
           red_clr_o, done_o, finished_o, cfg_err_o
  );

endinterface

// File: rtl/stage_sequencer_decode.sv
// Comparator ladder: maps a step value onto its stage index and flags a
// reduction clear when the step lands exactly on a masked boundary.
module stage_decode
  import seq_pkg::*;
(
  input  step_t                 step_i,
  input  table_t                bnd_i,
  input  logic [NUM_STAGES-1:0] mask_i,
  output stage_t                stage_c_o,
  output logic                  clr_hit_c_o
);

  // Scan from the top so the smallest matching index wins; equal boundaries skip empty stages
  always_comb begin
    stage_c_o   = stage_t'(NUM_STAGES);
    clr_hit_c_o = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (step_i < bnd_i[k*STEP_W +: STEP_W]) stage_c_o = stage_t'(k);
    end
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (mask_i[k] && (step_i == bnd_i[k*STEP_W +: STEP_W])) clr_hit_c_o = 1'b1;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Step/stage sequencer: latches a job table, walks the step counter with a
// stall handshake, drains the arithmetic pipe and reports done.
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MODE_STAGES = 2,
  parameter int unsigned CHAIN_STAGE = 2,
  parameter int unsigned DRAIN_CYC   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  stage_sequencer_if.slave   bus
);

  localparam int unsigned DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  typedef logic [DRN_W-1:0] drn_t;
  localparam drn_t DRN_LAST = drn_t'(DRAIN_CYC - 1);

  seq_state_e state_q, state_d;
  step_t      step_q, step_d;
  stage_t     stage_q, stage_d;
  table_t     bnd_q, bnd_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  drn_t       drain_q, drain_d;
  logic       busy_q, busy_d;
  logic       mode_q, mode_d;
  logic       add_sel_q, add_sel_d;
  logic       red_clr_q, red_clr_d;
  logic       done_q, done_d;
  logic       finished_q, finished_d;
  logic       cfg_err_q, cfg_err_d;

  logic   accept_c;
  logic   cfg_ok_c;
  step_t  dec_step_c;
  table_t dec_bnd_c;
  logic [NUM_STAGES-1:0] dec_mask_c;
  stage_t dec_stage_c;
  logic   dec_clr_c;
  step_t  bnd_last_c;

  assign accept_c   = bus.start_i && ((state_q == IDLE) || (state_q == DONE));
  assign cfg_ok_c   = cfg_valid(bus.boundary_i);
  assign bnd_last_c = bnd_q[(NUM_STAGES-1)*STEP_W +: STEP_W];

  // On a start the incoming table is decoded at step 0 before it is latched
  assign dec_step_c = accept_c ? '0 : step_q + step_t'(1);
  assign dec_bnd_c  = accept_c ? bus.boundary_i : bnd_q;
  assign dec_mask_c = accept_c ? bus.clr_mask_i : mask_q;

  stage_decode u_decode (
    .step_i      (dec_step_c),
    .bnd_i       (dec_bnd_c),
    .mask_i      (dec_mask_c),
    .stage_c_o   (dec_stage_c),
    .clr_hit_c_o (dec_clr_c)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    stage_d   = stage_q;
    bnd_d     = bnd_q;
    mask_d    = mask_q;
    drain_d   = drain_q;
    red_clr_d = 1'b0;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          if (cfg_ok_c) begin
            state_d   = RUN;
            step_d    = '0;
            stage_d   = dec_stage_c;
            red_clr_d = 1'b1;
            bnd_d     = bus.boundary_i;
            mask_d    = bus.clr_mask_i;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!bus.stall_i) begin
          step_d    = dec_step_c;
          stage_d   = dec_stage_c;
          red_clr_d = dec_clr_c;
          if (dec_step_c == bnd_last_c) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRN_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + drn_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d == RUN) || (state_d == DRAIN);
    finished_d = (state_d == DONE);
    mode_d     = (32'(stage_d) < MODE_STAGES);
    add_sel_d  = (32'(stage_d) == CHAIN_STAGE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      step_q     <= '0;
      stage_q    <= '0;
      bnd_q      <= '0;
      mask_q     <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      mode_q     <= (MODE_STAGES > 0);
      add_sel_q  <= (CHAIN_STAGE == 0);
      red_clr_q  <= 1'b0;
      done_q     <= 1'b0;
      finished_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      stage_q    <= stage_d;
      bnd_q      <= bnd_d;
      mask_q     <= mask_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      mode_q     <= mode_d;
      add_sel_q  <= add_sel_d;
      red_clr_q  <= red_clr_d;
      done_q     <= done_d;
      finished_q <= finished_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.step_o     = step_q;
  assign bus.stage_o    = stage_q;
  assign bus.mode_o     = mode_q;
  assign bus.add_sel_o  = add_sel_q;
  assign bus.red_clr_o  = red_clr_q;
  assign bus.done_o     = done_q;
  assign bus.finished_o = finished_q;
  assign bus.cfg_err_o  = cfg_err_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: hand-computed step/stage/pulse
// expectations for nominal, stalled, sparse, bad-config, reset and restart jobs.
module tb_stage_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  stage_sequencer_if bus ();

  stage_sequencer #(
    .MODE_STAGES (2),
    .CHAIN_STAGE (2),
    .DRAIN_CYC   (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".busy"},    32'(bus.busy_o),     0);
    chk({tag, ".step"},    32'(bus.step_o),     0);
    chk({tag, ".stage"},   32'(bus.stage_o),    0);
    chk({tag, ".mode"},    32'(bus.mode_o),     1);
    chk({tag, ".add_sel"}, 32'(bus.add_sel_o),  0);
    chk({tag, ".red_clr"}, 32'(bus.red_clr_o),  0);
    chk({tag, ".done"},    32'(bus.done_o),     0);
    chk({tag, ".fin"},     32'(bus.finished_o), 0);
    chk({tag, ".cfg_err"}, 32'(bus.cfg_err_o),  0);
  endtask

  // Check one RUN/DRAIN cycle; mode/add_sel follow from the expected stage (MODE_STAGES=2, CHAIN_STAGE=2)
  task automatic chk_run(input string tag, input int st, input int sg, input int rc);
    chk({tag, ".step"},    32'(bus.step_o),     32'(st));
    chk({tag, ".stage"},   32'(bus.stage_o),    32'(sg));
    chk({tag, ".red_clr"}, 32'(bus.red_clr_o),  32'(rc));
    chk({tag, ".busy"},    32'(bus.busy_o),     1);
    chk({tag, ".done"},    32'(bus.done_o),     0);
    chk({tag, ".fin"},     32'(bus.finished_o), 0);
    chk({tag, ".mode"},    32'(bus.mode_o),     (sg < 2) ? 1 : 0);
    chk({tag, ".add_sel"}, 32'(bus.add_sel_o),  (sg == 2) ? 1 : 0);
  endtask

  task automatic adv(input string tag, input int st, input int sg, input int rc);
    tick();
    chk_run(tag, st, sg, rc);
  endtask

  // Four drain cycles: three still busy, then the done pulse, then finished holds
  task automatic drain_done(input string tag, input int st);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, ".drain_busy"}, 32'(bus.busy_o), 1);
      chk({tag, ".drain_done"}, 32'(bus.done_o), 0);
      chk({tag, ".drain_step"}, 32'(bus.step_o), 32'(st));
    end
    tick();
    chk({tag, ".done"},  32'(bus.done_o),     1);
    chk({tag, ".fin"},   32'(bus.finished_o), 1);
    chk({tag, ".busy"},  32'(bus.busy_o),     0);
    chk({tag, ".step"},  32'(bus.step_o),     32'(st));
    chk({tag, ".stage"}, 32'(bus.stage_o),    8);
    tick();
    chk({tag, ".done_pulse"}, 32'(bus.done_o),     0);
    chk({tag, ".fin_hold"},   32'(bus.finished_o), 1);
  endtask

  task automatic start_job(input logic [127:0] bnd, input logic [7:0] mask);
    bus.boundary_i = bnd;
    bus.clr_mask_i = mask;
    bus.start_i    = 1'b1;
    tick();
    bus.start_i    = 1'b0;
  endtask

  logic [127:0] tbl_lin;
  logic [127:0] tbl_sparse;
  logic [127:0] tbl_nonmono;
  logic [127:0] tbl_zero;
  logic [8:0]   clr_lin;

  initial begin
    tbl_lin     = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    tbl_sparse  = {16'd9, 16'd5, 16'd5, 16'd5, 16'd5, 16'd2, 16'd2, 16'd2};
    tbl_nonmono = {16'd10, 16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd3, 16'd4};
    tbl_zero    = '0;
    clr_lin     = 9'b0_1110_0101;  // clears at steps 0,2,5,6,7 for mask 8'h72

    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.stall_i    = 1'b0;
    bus.boundary_i = '0;
    bus.clr_mask_i = '0;
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b0;

    // Linear table, no stall
    start_job(tbl_lin, 8'h72);
    chk_run("t1.s0", 0, 0, 1);
    for (int s = 1; s <= 8; s++) adv("t1", s, s, 32'(clr_lin[s]));
    drain_done("t1", 8);

    // Restart from DONE, stall three cycles at steps 3 and 4, start held during RUN
    start_job(tbl_lin, 8'h72);
    chk_run("t2.restart", 0, 0, 1);
    adv("t2", 1, 1, 0);
    adv("t2", 2, 2, 1);
    adv("t2", 3, 3, 0);
    bus.stall_i = 1'b1;
    bus.start_i = 1'b1;
    for (int i = 0; i < 3; i++) adv("t2.stall3", 3, 3, 0);
    bus.start_i = 1'b0;
    bus.stall_i = 1'b0;
    adv("t2", 4, 4, 0);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) adv("t2.stall4", 4, 4, 0);
    bus.stall_i = 1'b0;
    adv("t2", 5, 5, 1);
    adv("t2", 6, 6, 1);
    adv("t2", 7, 7, 1);
    adv("t2", 8, 8, 0);
    drain_done("t2", 8);

    // Equal boundaries skip empty stages
    start_job(tbl_sparse, 8'h00);
    chk_run("t3.s0", 0, 0, 1);
    adv("t3", 1, 0, 0);
    adv("t3", 2, 3, 0);
    adv("t3", 3, 3, 0);
    adv("t3", 4, 3, 0);
    adv("t3", 5, 7, 0);
    adv("t3", 6, 7, 0);
    adv("t3", 7, 7, 0);
    adv("t3", 8, 7, 0);
    adv("t3", 9, 8, 0);
    drain_done("t3", 9);

    // Non-monotonic table rejected while in DONE; state and outputs hold
    start_job(tbl_nonmono, 8'hFF);
    chk("t4.nm.cfg_err", 32'(bus.cfg_err_o),  1);
    chk("t4.nm.busy",    32'(bus.busy_o),     0);
    chk("t4.nm.fin",     32'(bus.finished_o), 1);
    chk("t4.nm.step",    32'(bus.step_o),     9);
    tick();
    chk("t4.nm.pulse",   32'(bus.cfg_err_o),  0);
    chk("t4.nm.busy2",   32'(bus.busy_o),     0);

    // Zero last boundary rejected from IDLE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_job(tbl_zero, 8'h00);
    chk("t4.zero.cfg_err", 32'(bus.cfg_err_o), 1);
    chk("t4.zero.busy",    32'(bus.busy_o),    0);
    tick();
    chk("t4.zero.pulse",   32'(bus.cfg_err_o), 0);
    chk("t4.zero.busy2",   32'(bus.busy_o),    0);
    chk("t4.zero.step",    32'(bus.step_o),    0);

    // Reset mid-job, then a clean rerun
    start_job(tbl_lin, 8'h72);
    chk_run("t5.s0", 0, 0, 1);
    adv("t5", 1, 1, 0);
    adv("t5", 2, 2, 1);
    adv("t5", 3, 3, 0);
    rst = 1'b1;
    tick();
    chk_reset("t5.rst");
    rst = 1'b0;
    tick();
    chk_reset("t5.idle");
    start_job(tbl_lin, 8'h72);
    chk_run("t5.rerun.s0", 0, 0, 1);
    for (int s = 1; s <= 8; s++) adv("t5.rerun", s, s, 32'(clr_lin[s]));
    drain_done("t5.rerun", 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
